// File: rtl/sb_tx_arbiter_if.sv
// Sideband TX arbiter bus: requester handshakes, captured packet payloads and
// the serializer word interface.
//   master : arbiter side (drives serializer word, acks, grant, busy)
//   slave  : requester/serializer side (drives requests, payloads, ser_done)
interface sb_tx_arbiter_if;
    logic        i_pattern_req;
    logic        i_rdi_req;
    logic [63:0] i_rdi_header;
    logic        i_ltsm_req;
    logic [63:0] i_ltsm_header;
    logic        i_ltsm_has_data;
    logic [63:0] i_ltsm_data;
    logic        i_ser_done;
    logic        o_ser_valid;
    logic [63:0] o_ser_data;
    logic        o_rdi_ack;
    logic        o_ltsm_ack;
    logic [1:0]  o_grant;
    logic        o_busy;

    modport master (
        input  i_pattern_req, i_rdi_req, i_rdi_header,
        input  i_ltsm_req, i_ltsm_header, i_ltsm_has_data, i_ltsm_data,
        input  i_ser_done,
        output o_ser_valid, o_ser_data, o_rdi_ack, o_ltsm_ack, o_grant, o_busy
    );

    modport slave (
        output i_pattern_req, i_rdi_req, i_rdi_header,
        output i_ltsm_req, i_ltsm_header, i_ltsm_has_data, i_ltsm_data,
        output i_ser_done,
        input  o_ser_valid, o_ser_data, o_rdi_ack, o_ltsm_ack, o_grant, o_busy
    );
endinterface

// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter/sequencer. Shares one 64-bit serializer among the
// start-pattern generator, the RDI encoder and the LTSM encoder, sends one
// packet at a time, inserts GAP_CYCLES idle cycles after each packet and
// acknowledges each completed transfer.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (master) : request/payload inputs, serializer word + done,
//                  acks, grant (00 none/01 pattern/10 RDI/11 LTSM), busy
module sb_tx_arbiter #(
    parameter int unsigned GAP_CYCLES = 32,
    parameter logic [63:0] PATTERN    = 64'hAAAA_AAAA_AAAA_AAAA
) (
    input  logic           i_clk,
    input  logic           i_rst,
    sb_tx_arbiter_if.master bus
);
    localparam int unsigned      CNT_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_PAT  = 2'b01;
    localparam logic [1:0] GRANT_RDI  = 2'b10;
    localparam logic [1:0] GRANT_LTSM = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PATTERN,
        ST_SEND_HDR,
        ST_SEND_DATA,
        ST_GAP
    } state_t;

    state_t           state;
    logic             fair_ltsm;     // LTSM wins over RDI once after RDI completed with LTSM waiting
    logic             has_data_q;
    logic             data_pending;
    logic [63:0]      data_q;
    logic [CNT_W-1:0] gap_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            fair_ltsm       <= 1'b0;
            has_data_q      <= 1'b0;
            data_pending    <= 1'b0;
            data_q          <= '0;
            gap_cnt         <= '0;
            bus.o_ser_valid <= 1'b0;
            bus.o_ser_data  <= '0;
            bus.o_rdi_ack   <= 1'b0;
            bus.o_ltsm_ack  <= 1'b0;
            bus.o_grant     <= GRANT_NONE;
            bus.o_busy      <= 1'b0;
        end else begin
            bus.o_rdi_ack  <= 1'b0;
            bus.o_ltsm_ack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    data_pending <= 1'b0;
                    if (bus.i_pattern_req) begin
                        state           <= ST_PATTERN;
                        bus.o_ser_valid <= 1'b1;
                        bus.o_ser_data  <= PATTERN;
                        bus.o_grant     <= GRANT_PAT;
                        bus.o_busy      <= 1'b1;
                    end else if (bus.i_ltsm_req && (fair_ltsm || !bus.i_rdi_req)) begin
                        state           <= ST_SEND_HDR;
                        fair_ltsm       <= 1'b0;
                        has_data_q      <= bus.i_ltsm_has_data;
                        data_q          <= bus.i_ltsm_data;
                        bus.o_ser_valid <= 1'b1;
                        bus.o_ser_data  <= bus.i_ltsm_header;
                        bus.o_grant     <= GRANT_LTSM;
                        bus.o_busy      <= 1'b1;
                    end else if (bus.i_rdi_req) begin
                        state           <= ST_SEND_HDR;
                        has_data_q      <= 1'b0;
                        bus.o_ser_valid <= 1'b1;
                        bus.o_ser_data  <= bus.i_rdi_header;
                        bus.o_grant     <= GRANT_RDI;
                        bus.o_busy      <= 1'b1;
                    end
                end

                ST_PATTERN: begin
                    // Pattern words go back-to-back while requested; gap only at the end.
                    if (bus.i_ser_done && !bus.i_pattern_req) begin
                        state           <= ST_GAP;
                        gap_cnt         <= '0;
                        bus.o_ser_valid <= 1'b0;
                    end
                end

                ST_SEND_HDR: begin
                    if (bus.i_ser_done) begin
                        state           <= ST_GAP;
                        gap_cnt         <= '0;
                        bus.o_ser_valid <= 1'b0;
                        if (bus.o_grant == GRANT_LTSM && has_data_q) begin
                            data_pending <= 1'b1;
                        end else if (bus.o_grant == GRANT_RDI) begin
                            bus.o_rdi_ack <= 1'b1;
                            if (bus.i_ltsm_req) begin
                                fair_ltsm <= 1'b1;
                            end
                        end else begin
                            bus.o_ltsm_ack <= 1'b1;
                        end
                    end
                end

                ST_SEND_DATA: begin
                    if (bus.i_ser_done) begin
                        state           <= ST_GAP;
                        gap_cnt         <= '0;
                        data_pending    <= 1'b0;
                        bus.o_ser_valid <= 1'b0;
                        bus.o_ltsm_ack  <= 1'b1;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (data_pending) begin
                            state           <= ST_SEND_DATA;
                            data_pending    <= 1'b0;
                            bus.o_ser_valid <= 1'b1;
                            bus.o_ser_data  <= data_q;
                        end else begin
                            state       <= ST_IDLE;
                            bus.o_grant <= GRANT_NONE;
                            bus.o_busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Self-checking bench for sb_tx_arbiter: a serializer model pops expected
// words (data, grant, ack-after, gap length) from a scoreboard queue filled
// by the stimulus, and checks acks and inter-packet gaps.
module tb_sb_tx_arbiter;
    localparam int unsigned GAP = 32;
    localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

    // gap_kind: 0 unchecked, 1 exactly GAP, 2 back-to-back, 3 exactly GAP+1
    typedef struct {
        logic [63:0] data;
        logic [1:0]  grant;
        logic        ack;
        int          gap_kind;
    } exp_t;

    logic clk;
    logic rst;
    logic model_done;
    logic spur_done;
    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;
    int   words_seen;

    sb_tx_arbiter_if bus();

    sb_tx_arbiter #(.GAP_CYCLES(GAP), .PATTERN(PAT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    assign bus.i_ser_done = model_done | spur_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_exp(input logic [63:0] data, input logic [1:0] grant,
                            input logic ack, input int kind);
        exp_t e;
        e.data = data; e.grant = grant; e.ack = ack; e.gap_kind = kind;
        exp_q.push_back(e);
    endtask

    // Serializer model and output checker
    initial begin : ser_model
        exp_t cur;
        logic active, done_prev, e_rdi, e_ltsm;
        int   cnt, gap_cnt;
        active = 1'b0; done_prev = 1'b0; cnt = 0; gap_cnt = 0;
        cur.data = '0; cur.grant = '0; cur.ack = 1'b0; cur.gap_kind = 0;
        model_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0; done_prev = 1'b0; model_done = 1'b0; gap_cnt = 0; cnt = 0;
            end else begin
                e_rdi  = done_prev && cur.ack && (cur.grant == 2'b10);
                e_ltsm = done_prev && cur.ack && (cur.grant == 2'b11);
                if (e_rdi || bus.o_rdi_ack)   check_val("rdi_ack", bus.o_rdi_ack, e_rdi);
                if (e_ltsm || bus.o_ltsm_ack) check_val("ltsm_ack", bus.o_ltsm_ack, e_ltsm);
                if (done_prev) begin
                    active = 1'b0; done_prev = 1'b0; model_done = 1'b0; gap_cnt = 0;
                end
                if (bus.o_ser_valid && !active) begin
                    check_val("word_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        words_seen++;
                        check_val("ser_data", bus.o_ser_data, cur.data);
                        check_val("grant", bus.o_grant, cur.grant);
                        case (cur.gap_kind)
                            1: check_val("gap_hdr_data", gap_cnt, GAP);
                            2: check_val("gap_b2b", gap_cnt, 0);
                            3: check_val("gap_turnaround", gap_cnt, GAP + 1);
                            default: ;
                        endcase
                    end
                    active = 1'b1;
                    cnt = int'($urandom_range(5, 2)) - 1;
                end
                if (!bus.o_ser_valid) gap_cnt++;
                if (active) begin
                    if (cnt == 0) begin
                        model_done = 1'b1; done_prev = 1'b1;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Runs until scoreboard drained and DUT idle; drops reqs on ack / pattern count.
    task automatic run(input int rdi_drop_after, input int pat_words, input int budget);
        int rdi_acks, t, base;
        rdi_acks = 0; t = 0; base = words_seen;
        while (t < budget) begin
            @(negedge clk);
            t++;
            if (bus.o_rdi_ack) begin
                rdi_acks++;
                if (rdi_acks >= rdi_drop_after) bus.i_rdi_req = 1'b0;
            end
            if (bus.o_ltsm_ack) bus.i_ltsm_req = 1'b0;
            if (pat_words > 0 && (words_seen - base) >= pat_words) bus.i_pattern_req = 1'b0;
            if (exp_q.size() == 0 && !bus.o_busy && !bus.i_rdi_req &&
                !bus.i_ltsm_req && !bus.i_pattern_req) break;
        end
        check_val("run_in_budget", t < budget, 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c, base;
        logic seen;
        n_checks = 0; n_pass = 0; words_seen = 0; spur_done = 1'b0;
        rst = 1'b1;
        bus.i_pattern_req = 1'b0; bus.i_rdi_req = 1'b0; bus.i_ltsm_req = 1'b0;
        bus.i_rdi_header = '0; bus.i_ltsm_header = '0; bus.i_ltsm_data = '0;
        bus.i_ltsm_has_data = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_valid", bus.o_ser_valid, 0);
        check_val("rst_data", bus.o_ser_data, 0);
        check_val("rst_grant", bus.o_grant, 0);
        check_val("rst_busy", bus.o_busy, 0);
        check_val("rst_acks", {bus.o_rdi_ack, bus.o_ltsm_ack}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single RDI, with spurious ser_done in GAP
        bus.i_rdi_header = 64'h1234;
        push_exp(64'h1234, 2'b10, 1'b1, 0);
        bus.i_rdi_req = 1'b1;
        @(posedge clk); #1;
        check_val("rdi_valid_latency", bus.o_ser_valid, 1);
        check_val("rdi_busy", bus.o_busy, 1);
        seen = 1'b0; c = 0;
        while (!seen && c < 40) begin
            @(negedge clk); c++;
            seen = bus.o_rdi_ack;
        end
        check_val("rdi_ack_seen", seen, 1);
        bus.i_rdi_req = 1'b0;
        c = 0;
        while (bus.o_busy && c < 100) begin
            @(negedge clk); c++;
            if (c == 5) spur_done = 1'b1;
            if (c == 6) begin
                spur_done = 1'b0;
                check_val("gap_grant_hold", bus.o_grant, 2'b10);
            end
        end
        check_val("gap_to_idle_cycles", c, GAP);

        // Spurious ser_done in IDLE
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check_val("spur_idle_busy", bus.o_busy, 0);
        check_val("spur_idle_grant", bus.o_grant, 0);
        check_val("spur_idle_valid", bus.o_ser_valid, 0);
        repeat (2) @(negedge clk);

        // LTSM header + data; data input changed after grant must be ignored
        bus.i_ltsm_header = 64'hA5; bus.i_ltsm_data = 64'h5A; bus.i_ltsm_has_data = 1'b1;
        push_exp(64'hA5, 2'b11, 1'b0, 0);
        push_exp(64'h5A, 2'b11, 1'b1, 1);
        bus.i_ltsm_req = 1'b1;
        @(posedge clk); #1;
        bus.i_ltsm_data = 64'hDEAD_BEEF; bus.i_ltsm_header = 64'hFFFF;
        run(1, 0, 400);

        // Pattern + RDI + LTSM together
        bus.i_rdi_header = 64'h1111; bus.i_ltsm_header = 64'h2222; bus.i_ltsm_has_data = 1'b0;
        push_exp(PAT, 2'b01, 1'b0, 0);
        push_exp(PAT, 2'b01, 1'b0, 2);
        push_exp(PAT, 2'b01, 1'b0, 2);
        push_exp(64'h1111, 2'b10, 1'b1, 3);
        push_exp(64'h2222, 2'b11, 1'b1, 3);
        bus.i_pattern_req = 1'b1; bus.i_rdi_req = 1'b1; bus.i_ltsm_req = 1'b1;
        run(1, 3, 2000);

        // RDI held continuously, LTSM pending: fairness gives RDI, LTSM, RDI
        bus.i_rdi_header = 64'h3333; bus.i_ltsm_header = 64'h4444;
        push_exp(64'h3333, 2'b10, 1'b1, 0);
        push_exp(64'h4444, 2'b11, 1'b1, 3);
        push_exp(64'h3333, 2'b10, 1'b1, 3);
        bus.i_rdi_req = 1'b1; bus.i_ltsm_req = 1'b1;
        run(2, 0, 2000);

        // Reset during SEND_DATA, then restart from header
        bus.i_ltsm_header = 64'h77; bus.i_ltsm_data = 64'h88; bus.i_ltsm_has_data = 1'b1;
        push_exp(64'h77, 2'b11, 1'b0, 0);
        push_exp(64'h88, 2'b11, 1'b1, 1);
        base = words_seen;
        bus.i_ltsm_req = 1'b1;
        c = 0;
        while ((words_seen - base) < 2 && c < 300) begin
            @(negedge clk); c++;
        end
        check_val("reached_send_data", words_seen - base, 2);
        rst = 1'b1;
        #1;
        check_val("midrst_valid", bus.o_ser_valid, 0);
        check_val("midrst_data", bus.o_ser_data, 0);
        check_val("midrst_grant", bus.o_grant, 0);
        check_val("midrst_busy", bus.o_busy, 0);
        check_val("midrst_acks", {bus.o_rdi_ack, bus.o_ltsm_ack}, 0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        push_exp(64'h77, 2'b11, 1'b0, 0);
        push_exp(64'h88, 2'b11, 1'b1, 1);
        rst = 1'b0;
        run(1, 0, 400);

        repeat (3) @(negedge clk);
        check_val("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
